// File: rtl/mc_defs.sv
// mc_defs: shared definitions for the multi-cycle MIPS-lite controller.
// Holds the FSM state encodings, the opcode/funct values that the
// controller recognises, and the select encodings driven onto the
// datapath muxes (ALU op, extender op, next-PC source, GPR write data,
// GPR destination). Imported by the controller, the decoder, the
// datapath top and the bench so every party agrees on the numbers.
package mc_defs;

    // Debug-visible state numbering is fixed; the bench checks it directly.
    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_DCD   = 4'd1,
        S_EXE   = 4'd2,
        S_ALUWB = 4'd3,
        S_MADR  = 4'd4,
        S_MRD   = 4'd5,
        S_MWB   = 4'd6,
        S_MWR   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_HIGH  = 2'b10;

    localparam logic [1:0] NPC_PC4   = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_J     = 2'b10;
    localparam logic [1:0] NPC_JR    = 2'b11;

    localparam logic [1:0] WD_ALU    = 2'b00;
    localparam logic [1:0] WD_DM     = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    localparam logic [1:0] RD_RT     = 2'b00;
    localparam logic [1:0] RD_RD     = 2'b01;
    localparam logic [1:0] RD_R31    = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   op, funct      in   IR[31:26] and IR[5:0]
//   isRtypeAlu     out  addu or subu
//   isOri .. isJr  out  one-hot class flags for each supported encoding
//   isIllegal      out  set when no supported class matches
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       isRtypeAlu,
    output logic       isOri,
    output logic       isLui,
    output logic       isLw,
    output logic       isSw,
    output logic       isBeq,
    output logic       isJ,
    output logic       isJal,
    output logic       isJr,
    output logic       isIllegal
);

    always_comb begin
        isRtypeAlu = 1'b0;
        isOri      = 1'b0;
        isLui      = 1'b0;
        isLw       = 1'b0;
        isSw       = 1'b0;
        isBeq      = 1'b0;
        isJ        = 1'b0;
        isJal      = 1'b0;
        isJr       = 1'b0;
        isIllegal  = 1'b0;
        case (op)
            OP_RTYPE: begin
                // Only three funct codes exist in this core; any other
                // R-type encoding is treated as unsupported.
                if (funct == FN_ADDU || funct == FN_SUBU) isRtypeAlu = 1'b1;
                else if (funct == FN_JR)                  isJr       = 1'b1;
                else                                      isIllegal  = 1'b1;
            end
            OP_ORI:  isOri     = 1'b1;
            OP_LUI:  isLui     = 1'b1;
            OP_LW:   isLw      = 1'b1;
            OP_SW:   isSw      = 1'b1;
            OP_BEQ:  isBeq     = 1'b1;
            OP_J:    isJ       = 1'b1;
            OP_JAL:  isJal     = 1'b1;
            default: isIllegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-lite datapath.
// One datapath stage per clock: fetch, decode, then a class-specific
// tail (ALU, memory, branch or jump) before returning to fetch.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op, funct, zero   IR fields and ALU zero flag
//   pc_wr, ir_wr, reg_wr, mem_wr   write strobes (forced 0 during rst)
//   reg_dst, wd_sel, alu_src, alu_op, ext_op, npc_sel   datapath selects
//   illegal           one-cycle pulse in decode on an unsupported encoding
//   instr_cnt         retired-instruction count, wraps modulo 2^CNT_W
//   state             current FSM state for debug
module mc_ctrl
    import mc_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic [1:0]       npc_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state
);

    state_t           curState;
    logic [CNT_W-1:0] instrCnt;
    logic             isRtypeAlu, isOri, isLui, isLw, isSw;
    logic             isBeq, isJ, isJal, isJr, isIllegal;
    logic             retiring;

    mc_decode decodeInst (
        .op        (op),
        .funct     (funct),
        .isRtypeAlu(isRtypeAlu),
        .isOri     (isOri),
        .isLui     (isLui),
        .isLw      (isLw),
        .isSw      (isSw),
        .isBeq     (isBeq),
        .isJ       (isJ),
        .isJal     (isJal),
        .isJr      (isJr),
        .isIllegal (isIllegal)
    );

    // Every one of these states always hands back to fetch, so being in
    // one of them means an instruction completes at this edge.
    assign retiring = (curState == S_ALUWB) || (curState == S_MWB) ||
                      (curState == S_MWR)   || (curState == S_BR)  ||
                      (curState == S_JMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            curState <= S_IF;
            instrCnt <= '0;
        end else begin
            case (curState)
                S_IF:   curState <= S_DCD;
                S_DCD: begin
                    if (isRtypeAlu || isOri || isLui) curState <= S_EXE;
                    else if (isLw || isSw)            curState <= S_MADR;
                    else if (isBeq)                   curState <= S_BR;
                    else if (isJ || isJal || isJr)    curState <= S_JMP;
                    else                              curState <= S_IF;
                end
                S_EXE:  curState <= S_ALUWB;
                S_MADR: curState <= isLw ? S_MRD : S_MWR;
                S_MRD:  curState <= S_MWB;
                default: curState <= S_IF;
            endcase
            if (retiring) instrCnt <= instrCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore decode of state plus the held IR fields; the only input that
    // passes straight through is zero onto pc_wr in the branch state.
    always_comb begin
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        reg_wr  = 1'b0;
        mem_wr  = 1'b0;
        reg_dst = RD_RT;
        wd_sel  = WD_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = EXT_ZERO;
        npc_sel = NPC_PC4;
        illegal = 1'b0;
        case (curState)
            S_IF: begin
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            S_DCD: illegal = isIllegal;
            S_EXE, S_ALUWB: begin
                // Write-back keeps the execute selects so the ALU result
                // stays stable while the register file captures it.
                if (isOri) begin
                    alu_op  = ALU_OR;
                    alu_src = 1'b1;
                    ext_op  = EXT_ZERO;
                end else if (isLui) begin
                    alu_op  = ALU_PASSB;
                    alu_src = 1'b1;
                    ext_op  = EXT_HIGH;
                end else if (funct == FN_SUBU) begin
                    alu_op  = ALU_SUB;
                end
                if (curState == S_ALUWB) begin
                    reg_wr  = 1'b1;
                    reg_dst = isRtypeAlu ? RD_RD : RD_RT;
                end
            end
            S_MADR, S_MRD, S_MWR: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                mem_wr  = (curState == S_MWR);
            end
            S_MWB: begin
                reg_wr = 1'b1;
                wd_sel = WD_DM;
            end
            S_BR: begin
                alu_op  = ALU_SUB;
                npc_sel = NPC_BR;
                pc_wr   = zero;
            end
            S_JMP: begin
                pc_wr = 1'b1;
                if (isJr) begin
                    npc_sel = NPC_JR;
                end else begin
                    npc_sel = NPC_J;
                    if (isJal) begin
                        reg_wr  = 1'b1;
                        reg_dst = RD_R31;
                        wd_sel  = WD_PC;
                    end
                end
            end
            default: ;
        endcase
        // Reset must not let any in-flight instruction write anything.
        if (rst) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            mem_wr  = 1'b0;
            illegal = 1'b0;
        end
    end

    assign instr_cnt = instrCnt;
    assign state     = curState;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl with a per-cycle scoreboard.
// Each instruction pushes its expected per-cycle output vectors, written
// out as literal tables, and the vectors are popped and compared once per
// clock. The counter is narrowed to 4 bits so the wrap is reachable.
module tb_mc_ctrl;
    import mc_defs::*;

    localparam int CW = 4;

    typedef struct packed {
        logic [3:0]    st;
        logic          pcWr;
        logic          irWr;
        logic          regWr;
        logic          memWr;
        logic [1:0]    regDst;
        logic [1:0]    wdSel;
        logic          aluSrc;
        logic [1:0]    aluOp;
        logic [1:0]    extOp;
        logic [1:0]    npcSel;
        logic          ill;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          zero;
    logic          pc_wr, ir_wr, reg_wr, mem_wr, alu_src, illegal;
    logic [1:0]    reg_dst, wd_sel, alu_op, ext_op, npc_sel;
    logic [CW-1:0] instr_cnt;
    logic [3:0]    state;

    vec_t          expQ[$];
    string         tagQ[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] expCnt = '0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .pc_wr    (pc_wr),
        .ir_wr    (ir_wr),
        .reg_wr   (reg_wr),
        .mem_wr   (mem_wr),
        .reg_dst  (reg_dst),
        .wd_sel   (wd_sel),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .ext_op   (ext_op),
        .npc_sel  (npc_sel),
        .illegal  (illegal),
        .instr_cnt(instr_cnt),
        .state    (state)
    );

    // strb packs {pc_wr, ir_wr, reg_wr, mem_wr}.
    task automatic pushVec(input string tag, input logic [3:0] st, input logic [3:0] strb,
                           input logic [1:0] rd, input logic [1:0] wd, input logic src,
                           input logic [1:0] aop, input logic [1:0] eop,
                           input logic [1:0] npc, input logic ill);
        vec_t v;
        v.st = st;
        {v.pcWr, v.irWr, v.regWr, v.memWr} = strb;
        v.regDst = rd;
        v.wdSel  = wd;
        v.aluSrc = src;
        v.aluOp  = aop;
        v.extOp  = eop;
        v.npcSel = npc;
        v.ill    = ill;
        v.cnt    = expCnt;
        expQ.push_back(v);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        vec_t  e;
        vec_t  a;
        string t;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard-empty observed=%0d expected=1 entries", expQ.size());
            return;
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        a = '{state, pc_wr, ir_wr, reg_wr, mem_wr, reg_dst, wd_sel, alu_src,
              alu_op, ext_op, npc_sel, illegal, instr_cnt};
        assert (a === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, a, e);
        end
    endtask

    task automatic drain();
        while (expQ.size() > 0) begin
            checkOutput();
            @(negedge clk);
            #1;
        end
    endtask

    // Entered at a fetch cycle; leaves at the next fetch cycle.
    task automatic applyStimulus(input string tag, input logic [5:0] o,
                                 input logic [5:0] f, input logic z);
        logic legal;
        op    = o;
        funct = f;
        zero  = z;
        #1;
        legal = 1'b1;
        pushVec({tag, ".IF"}, 4'd0, 4'b1100, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        case (o)
            6'b000000: begin
                if (f == 6'b100001) begin
                    pushVec({tag, ".DCD"},   4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                    pushVec({tag, ".EXE"},   4'd2, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                    pushVec({tag, ".ALUWB"}, 4'd3, 4'b0010, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                end else if (f == 6'b100011) begin
                    pushVec({tag, ".DCD"},   4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                    pushVec({tag, ".EXE"},   4'd2, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
                    pushVec({tag, ".ALUWB"}, 4'd3, 4'b0010, 2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
                end else if (f == 6'b001000) begin
                    pushVec({tag, ".DCD"},   4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                    pushVec({tag, ".JMP"},   4'd9, 4'b1000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0);
                end else begin
                    legal = 1'b0;
                end
            end
            6'b001101: begin
                pushVec({tag, ".DCD"},   4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".EXE"},   4'd2, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".ALUWB"}, 4'd3, 4'b0010, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
            end
            6'b001111: begin
                pushVec({tag, ".DCD"},   4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".EXE"},   4'd2, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b11, 2'b10, 2'b00, 1'b0);
                pushVec({tag, ".ALUWB"}, 4'd3, 4'b0010, 2'b00, 2'b00, 1'b1, 2'b11, 2'b10, 2'b00, 1'b0);
            end
            6'b100011: begin
                pushVec({tag, ".DCD"},  4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".MADR"}, 4'd4, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
                pushVec({tag, ".MRD"},  4'd5, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
                pushVec({tag, ".MWB"},  4'd6, 4'b0010, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
            end
            6'b101011: begin
                pushVec({tag, ".DCD"},  4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".MADR"}, 4'd4, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
                pushVec({tag, ".MWR"},  4'd7, 4'b0001, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
            end
            6'b000100: begin
                pushVec({tag, ".DCD"}, 4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".BR"},  4'd8, {z, 3'b000}, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
            end
            6'b000010: begin
                pushVec({tag, ".DCD"}, 4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".JMP"}, 4'd9, 4'b1000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
            end
            6'b000011: begin
                pushVec({tag, ".DCD"}, 4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
                pushVec({tag, ".JMP"}, 4'd9, 4'b1010, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
            end
            default: legal = 1'b0;
        endcase
        if (!legal)
            pushVec({tag, ".DCD"}, 4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        drain();
        if (legal) expCnt = expCnt + 1'b1;
    endtask

    initial begin
        rst   = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        pushVec("reset", 4'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput();
        rst = 1'b0;
        #1;

        applyStimulus("addu",  OP_RTYPE, FN_ADDU, 1'b0);
        applyStimulus("subu",  OP_RTYPE, FN_SUBU, 1'b0);
        applyStimulus("ori",   OP_ORI,   6'b000101, 1'b0);
        applyStimulus("lui",   OP_LUI,   6'b000000, 1'b0);
        applyStimulus("lw",    OP_LW,    6'b000000, 1'b0);
        applyStimulus("sw",    OP_SW,    6'b000000, 1'b0);
        applyStimulus("beqT",  OP_BEQ,   6'b000000, 1'b1);
        applyStimulus("beqN",  OP_BEQ,   6'b000000, 1'b0);
        applyStimulus("j",     OP_J,     6'b000000, 1'b0);
        applyStimulus("jal",   OP_JAL,   6'b000000, 1'b0);
        applyStimulus("jr",    OP_RTYPE, FN_JR,     1'b0);
        applyStimulus("badOp", 6'b111111, 6'b000000, 1'b0);
        applyStimulus("badFn", OP_RTYPE, 6'b100000, 1'b0);

        // Counter now sits at 11; five jumps carry it through 15 back to 0.
        for (int i = 0; i < 5; i++) applyStimulus("jWrap", OP_J, 6'b000000, 1'b0);
        applyStimulus("jal2", OP_JAL, 6'b000000, 1'b0);

        // Abort a load in its memory-read cycle.
        op    = OP_LW;
        funct = 6'b000000;
        #1;
        pushVec("lwAbort.IF",   4'd0, 4'b1100, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        pushVec("lwAbort.DCD",  4'd1, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        pushVec("lwAbort.MADR", 4'd4, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
        drain();
        rst = 1'b1;
        #1;
        pushVec("lwAbort.MRDrst", 4'd5, 4'b0000, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput();
        @(negedge clk);
        #1;
        expCnt = '0;
        pushVec("lwAbort.after", 4'd0, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput();
        rst = 1'b0;
        #1;

        applyStimulus("adduPost", OP_RTYPE, FN_ADDU, 1'b0);
        pushVec("final.IF", 4'd0, 4'b1100, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the existing MIPS-lite datapath (pc, npc, im, gpr, alu, ext, dm) once the datapath is split with an instruction register (IR) between fetch and execute.
- Replaces the single-cycle combinational controller.
- Decodes op/funct from the IR and emits per-state write strobes and mux selects, one datapath stage per clock.
- Also keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]; stable from S_DCD until next S_IF
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in S_BR
- pc_wr  out  1  PC load enable
- ir_wr  out  1  IR load enable
- reg_wr  out  1  GPR write enable
- mem_wr  out  1  DM write enable
- reg_dst  out  2  write reg: 00 rt, 01 rd, 10 r31
- wd_sel  out  2  GPR write data: 00 ALU, 01 DM, 10 PC (already PC+4)
- alu_src  out  1  0 rt data, 1 extended immediate
- alu_op  out  2  00 add, 01 sub, 10 or, 11 pass-B
- ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- npc_sel  out  2  00 PC+4, 01 branch, 10 j target, 11 rs (jr)
- illegal  out  1  one-cycle pulse on unsupported encoding
- instr_cnt  out  CNT_W  retired-instruction count
- state  out  4  current state (debug)

Behaviour:
- Supported instructions: addu, subu, jr (op 000000 with funct 100001/100011/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- States:
  - S_IF = 0
  - S_DCD = 1
  - S_EXE = 2
  - S_ALUWB = 3
  - S_MADR = 4
  - S_MRD = 5
  - S_MWB = 6
  - S_MWR = 7
  - S_BR = 8
  - S_JMP = 9
- All outputs are Moore, decoded from state plus the held op/funct. Every unlisted strobe is 0. Unlisted selects are 00.
- S_IF: ir_wr=1, pc_wr=1, npc_sel=00. Next state S_DCD.
- S_DCD: no strobes.
  - R-type addu/subu, ori, lui -> S_EXE
  - lw/sw -> S_MADR
  - beq -> S_BR
  - j/jal/jr -> S_JMP
  - Anything else -> S_IF with illegal=1 for that cycle.
- S_EXE: sets alu_op, alu_src, ext_op.
  - addu: alu_op 00
  - subu: alu_op 01
  - ori: alu_op 10, alu_src 1, ext 00
  - lui: alu_op 11, alu_src 1, ext 10
  - Next state S_ALUWB.
- S_ALUWB: holds S_EXE selects, reg_wr=1, wd_sel=00, reg_dst=01 for R-type else 00. Next state S_IF.
- S_MADR: alu_op 00, alu_src 1, ext 01. lw -> S_MRD; sw -> S_MWR.
- S_MRD: holds address selects. Next state S_MWB.
- S_MWB: reg_wr=1, wd_sel=01, reg_dst=00. Next state S_IF.
- S_MWR: holds address selects, mem_wr=1. Next state S_IF.
- S_BR: alu_op 01, alu_src 0, npc_sel 01, pc_wr=zero (combinational from zero). Next state S_IF.
- S_JMP: pc_wr=1.
  - j: npc_sel 10
  - jal: npc_sel 10, reg_wr=1, reg_dst=10, wd_sel=10
  - jr: npc_sel 11
  - Next state S_IF.
- Latency in cycles:
  - R-type/ori/lui: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j/jal/jr: 3
  - illegal: 2
- instr_cnt: +1 on every transition into S_IF from S_ALUWB, S_MWB, S_MWR, S_BR or S_JMP. Not incremented on the illegal path. Wraps modulo 2^CNT_W.
- Reset: when rst=1 at an edge, state<=S_IF and instr_cnt<=0. While rst is high, all strobes are forced 0 and illegal=0. rst in any state aborts the instruction with no further writes. The first cycle after rst falls is S_IF.
- No state stalls; every state lasts exactly one cycle.

Decomposition:
- Package mc_defs: state encodings, opcode/funct constants, and the alu_op/ext_op/npc_sel/wd_sel/reg_dst encodings. These are shared with the datapath top and the bench.
- Sub-module mc_decode: combinational op/funct -> instruction-class one-hots (is_rtype_alu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jr, is_illegal).
- mc_ctrl holds only the FSM and counter.

Test Plan:
- rst high 3 cycles then low, op=000000 funct=100001 -> state 0,1,2,3,0; reg_wr=1 only in S_ALUWB with reg_dst=01; instr_cnt=1.
- lw (op 100011) -> states 0,1,4,5,6,0; ext_op=01 in 4/5; reg_wr=1, wd_sel=01 in S_MWB only; mem_wr never 1.
- sw then beq with zero=1, then beq with zero=0 -> mem_wr pulse in S_MWR; pc_wr=1, npc_sel=01 in the first S_BR; pc_wr=0 in the second; instr_cnt advances by 3.
- jal (op 000011) -> S_JMP drives pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wd_sel=10; jr (funct 001000) drives npc_sel=11, reg_wr=0.
- op=111111 -> S_DCD asserts illegal=1 and returns to S_IF; no write strobe; instr_cnt unchanged.
- rst asserted during S_MRD of lw -> next state S_IF; no reg_wr pulse; instr_cnt=0. Separately, preload instr_cnt near all-ones and verify wrap to 0.
